thermal_plant: RTL

Closed-loop partner of the thermostat controller. It consumes the controller's 2-bit mode command and produces the 5-bit room temperature the controller samples. It models the heater, cooler and room: the temperature ramps at a fixed rate while heating or cooling, and drifts toward ambient while idle. A settle interval after every mode change protects the actuators.

---
 rtl/thermal_plant.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/thermal_plant.sv
`default_nettype none
// ============================================================================
//  Module   : thermal_plant
//  Purpose  : Room / heater / cooler model closing the loop around a
//             thermostat controller. Temperature ramps at a fixed rate while
//             heating or cooling, drifts toward ambient while idle, and every
//             actuator change passes through a settle (dead-time) window.
//  Ports    : clk          - clock, rising edge
//             rst          - synchronous active-high reset
//             mode_i       - command: 00 idle, 10 heat, 01 cool, 11 invalid
//             ambient_i    - outside temperature
//             temp_o       - room temperature (registered)
//             temp_valid_o - one-cycle pulse when temp_o changes
//             active_o     - actuator actually applied (registered)
//             mode_err_o   - set the cycle after mode_i == 11 was sampled
//  Revision : 1.0 - initial release
// ============================================================================
module thermal_plant #(
    parameter int INIT_TEMP    = 20,
    parameter int HEAT_PERIOD  = 4,
    parameter int COOL_PERIOD  = 3,
    parameter int DRIFT_PERIOD = 8,
    parameter int SETTLE       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_i,
    input  logic [4:0] ambient_i,
    output logic [4:0] temp_o,
    output logic       temp_valid_o,
    output logic [1:0] active_o,
    output logic       mode_err_o
);

    // State codes for the three operating states equal the mode codes they
    // represent, so a state can be compared directly against the command.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_COOL   = 2'b01,
        ST_HEAT   = 2'b10,
        ST_SETTLE = 2'b11
    } state_t;

    localparam logic [4:0] c_INIT_TEMP  = 5'(INIT_TEMP);
    localparam logic [7:0] c_HEAT_LAST  = 8'(HEAT_PERIOD - 1);
    localparam logic [7:0] c_COOL_LAST  = 8'(COOL_PERIOD - 1);
    localparam logic [7:0] c_DRIFT_LAST = 8'(DRIFT_PERIOD - 1);
    localparam logic [7:0] c_SETTLE_M1  = 8'(SETTLE - 1);
    localparam logic [1:0] c_MODE_IDLE  = 2'b00;
    localparam logic [1:0] c_MODE_BAD   = 2'b11;

    state_t     state_q,  state_d;
    logic [1:0] target_q, target_d;
    logic [7:0] scnt_q,   scnt_d;
    logic [7:0] rcnt_q,   rcnt_d;
    logic [4:0] temp_q,   temp_d;
    logic [1:0] active_q, active_d;
    logic       tvalid_q;
    logic       err_q;

    logic [1:0] w_eff;
    logic [1:0] w_state_code;

    // Saturating +/-1 on a 6-bit widened copy: the carry/borrow bit marks
    // the out-of-range result.
    function automatic logic [4:0] f_inc(input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, t} + 6'd1;
        return s[5] ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [4:0] f_dec(input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, t} - 6'd1;
        return s[5] ? 5'd0 : s[4:0];
    endfunction

    // The invalid code is treated as idle everywhere.
    assign w_eff        = (mode_i == c_MODE_BAD) ? c_MODE_IDLE : mode_i;
    assign w_state_code = state_q;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        scnt_d   = scnt_q;
        rcnt_d   = rcnt_q;
        temp_d   = temp_q;
        active_d = active_q;

        case (state_q)
            ST_SETTLE: begin
                if (w_eff != target_q) begin
                    // Command moved again: retarget and restart dead-time.
                    target_d = w_eff;
                    scnt_d   = c_SETTLE_M1;
                end else if (scnt_q == 8'd0) begin
                    state_d  = state_t'(target_q);
                    rcnt_d   = 8'd0;
                    active_d = target_q;
                end else begin
                    scnt_d = scnt_q - 8'd1;
                end
            end
            default: begin
                if (w_eff != w_state_code) begin
                    state_d  = ST_SETTLE;
                    target_d = w_eff;
                    scnt_d   = c_SETTLE_M1;
                    rcnt_d   = 8'd0;
                    active_d = c_MODE_IDLE;
                end else begin
                    case (state_q)
                        ST_HEAT: begin
                            if (rcnt_q == c_HEAT_LAST) begin
                                rcnt_d = 8'd0;
                                temp_d = f_inc(temp_q);
                            end else begin
                                rcnt_d = rcnt_q + 8'd1;
                            end
                        end
                        ST_COOL: begin
                            if (rcnt_q == c_COOL_LAST) begin
                                rcnt_d = 8'd0;
                                temp_d = f_dec(temp_q);
                            end else begin
                                rcnt_d = rcnt_q + 8'd1;
                            end
                        end
                        default: begin
                            // Idle: the rate counter wraps even when temp
                            // already equals ambient.
                            if (rcnt_q == c_DRIFT_LAST) begin
                                rcnt_d = 8'd0;
                                if (temp_q < ambient_i) begin
                                    temp_d = f_inc(temp_q);
                                end else if (temp_q > ambient_i) begin
                                    temp_d = f_dec(temp_q);
                                end
                            end else begin
                                rcnt_d = rcnt_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= c_MODE_IDLE;
            scnt_q   <= 8'd0;
            rcnt_q   <= 8'd0;
            temp_q   <= c_INIT_TEMP;
            active_q <= c_MODE_IDLE;
            tvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            scnt_q   <= scnt_d;
            rcnt_q   <= rcnt_d;
            temp_q   <= temp_d;
            active_q <= active_d;
            // Pulse only on a real change; saturated or at-ambient steps
            // leave temp_d equal to temp_q.
            tvalid_q <= (temp_d != temp_q);
            err_q    <= (mode_i == c_MODE_BAD);
        end
    end

    assign temp_o       = temp_q;
    assign temp_valid_o = tvalid_q;
    assign active_o     = active_q;
    assign mode_err_o   = err_q;

endmodule
`default_nettype wire
